// File: rtl/host_load_ctrl.sv
// Host-side loader: parses a valid/ready command stream into SRAM write bursts
// and launches/awaits accelerator runs.
module host_load_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              task_complete,
  output logic              mem_wen_n,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_d,
  output logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_written
);

  typedef enum logic [2:0] {StHdr, StAddr, StData, StRun, StWaitLow} state_e;

  state_e              state_q, state_d;
  logic                sel_q, sel_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                wen_n_q, wen_n_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                start_q, start_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [15:0]         ww_q, ww_d;
  logic                accept;

  // Gated by reset so the port reads 0 during the reset cycle itself.
  assign in_ready = !reset &&
                    ((state_q == StHdr) || (state_q == StAddr) || (state_q == StData));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    remaining_d = remaining_q;
    ptr_d       = ptr_q;
    wen_n_d     = 1'b1;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    start_d     = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;
    ww_d        = ww_q;
    unique case (state_q)
      StHdr: begin
        if (accept) begin
          unique case (in_data[15:14])
            2'b00, 2'b01: begin
              sel_d       = in_data[14];
              remaining_d = in_data[LEN_W-1:0];
              state_d     = StAddr;
            end
            2'b10: begin
              start_d = 1'b1;
              state_d = StRun;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      StAddr: begin
        if (accept) begin
          ptr_d   = in_data[ADDR_W-1:0];
          state_d = StData;
        end
      end
      StData: begin
        if (accept) begin
          wen_n_d     = 1'b0;
          addr_d      = ptr_q;
          wdata_d     = in_data;
          ptr_d       = ptr_q + ADDR_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (ww_q != 16'hFFFF) ww_d = ww_q + 16'd1;
          if (remaining_q == '0) state_d = StHdr;
        end
      end
      StRun: begin
        if (task_complete) begin
          done_d  = 1'b1;
          state_d = StWaitLow;
        end
      end
      StWaitLow: begin
        // A completion level left high must not satisfy the next run.
        if (!task_complete) state_d = StHdr;
      end
      default: state_d = StHdr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StHdr;
      sel_q       <= 1'b0;
      remaining_q <= '0;
      ptr_q       <= '0;
      wen_n_q     <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ww_q        <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      remaining_q <= remaining_d;
      ptr_q       <= ptr_d;
      wen_n_q     <= wen_n_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      start_q     <= start_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ww_q        <= ww_d;
    end
  end

  assign mem_wen_n     = wen_n_q;
  assign mem_sel       = sel_q;
  assign mem_addr      = addr_q;
  assign mem_d         = wdata_q;
  assign start         = start_q;
  assign busy          = (state_q == StRun);
  assign done          = done_q;
  assign err           = err_q;
  assign words_written = ww_q;

endmodule

// File: tb/tb_host_load_ctrl.sv
// Self-checking bench for host_load_ctrl: command-level write model plus
// run-handshake timing model, with randomized bursts, bubbles and run lengths.
module tb_host_load_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        task_complete;
  logic        mem_wen_n;
  logic        mem_sel;
  logic [7:0]  mem_addr;
  logic [15:0] mem_d;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_written;

  host_load_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .task_complete(task_complete),
    .mem_wen_n    (mem_wen_n),
    .mem_sel      (mem_sel),
    .mem_addr     (mem_addr),
    .mem_d        (mem_d),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [7:0]  addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          ww_model = 0;
  logic [7:0]  last_addr;
  logic [15:0] last_data;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every observed SRAM write must be the next expected one, one cycle after accept.
  always @(negedge clk) begin
    if (mem_wen_n === 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got sel=%b addr=%h data=%h", mem_sel, mem_addr, mem_d);
      end else begin
        mon_e = exp_q.pop_front();
        if ({mem_sel, mem_addr, mem_d} !== {mon_e.sel, mon_e.addr, mon_e.data}
            || cyc != mon_e.cyc) begin
          failures++;
          $display("FAIL write got sel=%b addr=%h data=%h cyc=%0d want sel=%b addr=%h data=%h cyc=%0d",
                   mem_sel, mem_addr, mem_d, cyc, mon_e.sel, mon_e.addr, mon_e.data, mon_e.cyc);
        end
      end
    end
  end

  task automatic send(input logic [15:0] w, input logic is_data, input logic sel,
                      input logic [7:0] addr);
    int n;
    wr_t e;
    n = 0;
    in_data  = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready word=%h got in_ready=%b want 1", w, in_ready);
    end else if (is_data) begin
      e.sel = sel; e.addr = addr; e.data = w; e.cyc = cyc + 1;
      exp_q.push_back(e);
      if (ww_model < 65535) ww_model++;
      last_addr = addr;
      last_data = w;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // data_base != 0 gives data_base+i, otherwise random data.
  task automatic load_cmd(input logic cmd, input logic [7:0] base, input int n,
                          input logic [15:0] data_base, input int bubble_pct);
    logic [15:0] w;
    send({1'b0, cmd, 6'($urandom), 8'(n - 1)}, 1'b0, 1'b0, 8'h0);
    send({8'($urandom), base}, 1'b0, 1'b0, 8'h0);
    for (int i = 0; i < n; i++) begin
      if (int'($urandom_range(99)) < bubble_pct) idle($urandom_range(1, 2));
      w = (data_base != 16'h0) ? data_base + 16'(i) : 16'($urandom);
      send(w, 1'b1, cmd, 8'(int'(base) + i));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; task_complete = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL reset_in_ready got %b want 0", in_ready);
    end
    reset = 1'b0;
    exp_q.delete();
    ww_model = 0;
    #1;
    checks++;
    if ({in_ready, mem_wen_n, mem_sel, start, busy, done, err} !== 7'b1100000) begin
      failures++;
      $display("FAIL reset_ctrl got rdy,wen_n,sel,start,busy,done,err=%b want 1100000",
               {in_ready, mem_wen_n, mem_sel, start, busy, done, err});
    end
    checks++;
    if ({mem_addr, mem_d, words_written} !== 40'h0) begin
      failures++;
      $display("FAIL reset_data got addr=%h d=%h ww=%0d want 0", mem_addr, mem_d, words_written);
    end
  endtask

  task automatic test_load_basic();
    load_cmd(1'b0, 8'h10, 4, 16'h00A0, 0);
    idle(2);
    checks++;
    if (exp_q.size() != 0 || words_written !== 16'(ww_model)) begin
      failures++;
      $display("FAIL load_basic got pending=%0d ww=%0d want 0 ww=%0d",
               exp_q.size(), words_written, ww_model);
    end
    checks++;
    if ({mem_sel, mem_addr, mem_d, mem_wen_n} !== {1'b0, 8'h13, 16'h00A3, 1'b1}) begin
      failures++;
      $display("FAIL load_basic_hold got sel=%b addr=%h d=%h wen_n=%b want 0 13 00a3 1",
               mem_sel, mem_addr, mem_d, mem_wen_n);
    end
  endtask

  task automatic test_wrap_bubble();
    load_cmd(1'b1, 8'hFF, 2, 16'h00B0, 100);
    idle(2);
    checks++;
    if (exp_q.size() != 0 || words_written !== 16'(ww_model)) begin
      failures++;
      $display("FAIL wrap got pending=%0d ww=%0d want 0 ww=%0d",
               exp_q.size(), words_written, ww_model);
    end
    checks++;
    if ({mem_sel, mem_addr, mem_d} !== {1'b1, 8'h00, 16'h00B1}) begin
      failures++;
      $display("FAIL wrap_hold got sel=%b addr=%h d=%h want 1 00 00b1", mem_sel, mem_addr, mem_d);
    end
  endtask

  // task_complete is 1 for run-relative cycles [l, l+h); k=0 is the cycle after the header.
  task automatic test_start(input int l, input int h, input logic pre);
    logic [3:0] got, want;
    task_complete = pre;
    send(16'h8000, 1'b0, 1'b0, 8'h0);
    for (int k = 0; k < l + h + 4; k++) begin
      task_complete = (k >= l && k < l + h);
      @(negedge clk);
      got  = {start, busy, done, in_ready};
      want = {k == 0, k <= l, k == l + 1, k > l + h};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL start_seq l=%0d h=%0d k=%0d got start,busy,done,rdy=%b want %b",
                 l, h, k, got, want);
      end
      @(posedge clk);
      #1;
    end
    task_complete = 1'b0;
  endtask

  task automatic test_reserved();
    send({2'b11, 14'($urandom)}, 1'b0, 1'b0, 8'h0);
    idle(1);
    checks++;
    if (err !== 1'b1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL reserved got err=%b pending=%0d want 1 0", err, exp_q.size());
    end
    load_cmd(1'b0, 8'($urandom), 1, 16'h0, 0);
    idle(2);
    checks++;
    if (err !== 1'b1 || exp_q.size() != 0 || words_written !== 16'(ww_model)) begin
      failures++;
      $display("FAIL reserved_after got err=%b pending=%0d ww=%0d want 1 0 %0d",
               err, exp_q.size(), words_written, ww_model);
    end
  endtask

  task automatic test_back_to_back();
    load_cmd(1'b0, 8'($urandom), 3, 16'h0, 0);
    load_cmd(1'b1, 8'($urandom), 2, 16'h0, 0);
    idle(2);
    checks++;
    if (exp_q.size() != 0 || words_written !== 16'(ww_model)) begin
      failures++;
      $display("FAIL back_to_back got pending=%0d ww=%0d want 0 ww=%0d",
               exp_q.size(), words_written, ww_model);
    end
  endtask

  task automatic test_random_loads();
    repeat (6) load_cmd(1'($urandom), 8'($urandom), $urandom_range(1, 20), 16'h0, 30);
    load_cmd(1'($urandom), 8'($urandom), 256, 16'h0, 0);
    idle(2);
    checks++;
    if (exp_q.size() != 0 || words_written !== 16'(ww_model)) begin
      failures++;
      $display("FAIL random_loads got pending=%0d ww=%0d want 0 ww=%0d",
               exp_q.size(), words_written, ww_model);
    end
    checks++;
    if ({mem_addr, mem_d} !== {last_addr, last_data}) begin
      failures++;
      $display("FAIL random_hold got addr=%h d=%h want %h %h", mem_addr, mem_d, last_addr, last_data);
    end
  endtask

  task automatic test_reset_mid_burst();
    send({2'b00, 6'h0, 8'd4}, 1'b0, 1'b0, 8'h0);
    send(16'h0040, 1'b0, 1'b0, 8'h0);
    send(16'h1111, 1'b1, 1'b0, 8'h40);
    send(16'h2222, 1'b1, 1'b0, 8'h41);
    in_data = 16'h3333; in_valid = 1'b1; reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL midreset_in_ready got %b want 0", in_ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0;
    ww_model = 0;
    #1;
    checks++;
    if ({in_ready, mem_wen_n, mem_sel, start, busy, done, err} !== 7'b1100000
        || {mem_addr, mem_d, words_written} !== 40'h0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL midreset got rdy..err=%b addr=%h d=%h ww=%0d pending=%0d want 1100000 0 0 0 0",
               {in_ready, mem_wen_n, mem_sel, start, busy, done, err}, mem_addr, mem_d,
               words_written, exp_q.size());
    end
    load_cmd(1'b1, 8'h20, 3, 16'h0, 0);
    idle(2);
    checks++;
    if (exp_q.size() != 0 || words_written !== 16'(ww_model)) begin
      failures++;
      $display("FAIL after_reset_load got pending=%0d ww=%0d want 0 ww=%0d",
               exp_q.size(), words_written, ww_model);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_basic();
    test_wrap_bubble();
    test_start(5, 3, 1'b0);
    test_start(0, 2, 1'b1);
    repeat (3) test_start($urandom_range(0, 6), $urandom_range(1, 4), 1'b0);
    test_reserved();
    test_back_to_back();
    test_random_loads();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/host_load_ctrl.md
# host_load_ctrl

Host-side loader that sits directly upstream of the accelerator top level. It accepts a 16-bit valid/ready command stream from the host or testbench and writes packet words into the instruction packet SRAM (IMEM) or the big FV SRAM through a shared SRAM write port. On a START command it pulses the accelerator start, then waits for `task_complete` before accepting further commands. It replaces direct testbench preloading of the SRAMs.

## Interface
- `DATA_W`, 16, stream and SRAM word width; must be ≥16.
- `ADDR_W`, 8, SRAM address width; addresses wrap modulo 2^ADDR_W.
- `LEN_W`, 8, burst length field width; a burst carries len+1 words (1..2^LEN_W).

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `in_data` in DATA_W: host stream word.
- `in_valid` in 1: host word valid.
- `in_ready` out 1: loader accepts the word this cycle.
- `task_complete` in 1: accelerator finished (level, from packet controller).
- `mem_wen_n` out 1: SRAM write enable, active low.
- `mem_sel` out 1: 0 = IMEM SRAM, 1 = FV SRAM.
- `mem_addr` out ADDR_W: SRAM write address.
- `mem_d` out DATA_W: SRAM write data.
- `start` out 1: one-cycle pulse launching the accelerator.
- `busy` out 1: accelerator running (RUN state).
- `done` out 1: one-cycle pulse when the run completes.
- `err` out 1: sticky error flag, cleared only by reset.
- `words_written` out 16: saturating count of SRAM writes since reset.

## Operation
- Transfer happens when `in_valid && in_ready`.
- Header word: [15:14] cmd (00 LOAD_IMEM, 01 LOAD_FV, 10 START, 11 reserved), [13:LEN_W] ignored, [LEN_W-1:0] len.
- FSM states: HDR, ADDR, DATA, RUN, WAIT_LOW.
- HDR: accept header.
  - 00/01 → latch target into `mem_sel`, latch len into `remaining` → ADDR.
  - 10 → pulse `start` next cycle → RUN.
  - 11 → set `err`, drop the word, stay in HDR.
- ADDR: accept one word; base address = word[ADDR_W-1:0] → DATA; offset cleared.
- DATA: each accepted word is written to base+offset (ADDR_W bits, wraps 2^ADDR_W-1 → 0). Offset increments; `remaining` decrements. The word accepted with `remaining`==0 is the last; next state is HDR.
- RUN: `in_ready`=0, `busy`=1. When `task_complete`=1, pulse `done` → WAIT_LOW.
- WAIT_LOW: `in_ready`=0. Stay until `task_complete`=0 → HDR. This prevents a stale level from re-completing the next run.
- `in_ready`=1 in HDR, ADDR and DATA regardless of `in_valid`. Bubbles (`in_valid`=0) stall the FSM with no write.
- `words_written` increments on each write; saturates at 16'hFFFF.
- `err` does not block operation.

## Timing
- Reset values: `in_ready`=0 during the reset cycle and 1 the cycle after. `mem_wen_n`=1, `mem_sel`=0, `mem_addr`=0, `mem_d`=0, `start`=0, `busy`=0, `done`=0, `err`=0, `words_written`=0. FSM enters HDR.
- Write latency: a data word accepted in cycle t appears registered as `mem_wen_n`=0 with addr/data in cycle t+1, held one cycle only. `mem_addr`/`mem_d` hold their last values when idle.
- Throughput: one SRAM write per cycle at full stream rate. The last write of a burst and the next header can be back-to-back.
- `start` asserts the cycle after the START header is accepted; `busy` rises the same cycle.
- Completion: `task_complete` is sampled in RUN at cycle t; `done`=1 and `busy`=0 at t+1.
- If `task_complete` is already 1 on RUN entry, the run completes one cycle later. The `start` pulse still occurs.
- Reset mid-burst or mid-run aborts immediately to the reset values. Partial SRAM contents are not rolled back.
- len field of 2^LEN_W-1 writes 2^LEN_W words; with the default 8/8 this covers all of SRAM exactly once.

## Test plan
- Reset, then LOAD_IMEM len=3 base=0x10 with data A0..A3 at full rate. Expect writes (0,0x10,A0)…(0,0x13,A3) on consecutive cycles, one cycle after each accept; `words_written`=4.
- LOAD_FV len=1 base=0xFF with data B0,B1 and an `in_valid` bubble between them. Expect write 0xFF←B0, then 0x00←B1 (wrap); `mem_sel`=1; no write in the bubble cycle.
- START with `task_complete` low for 5 cycles, then high for 3 cycles. Expect `start` for one cycle; `busy` high with `in_ready`=0 throughout; a single `done` pulse; return to HDR only after `task_complete` drops.
- Header cmd=11. Expect `err`=1 and no write. A following LOAD_IMEM len=0 still writes 1 word; `err` stays 1.
- Assert `reset` in the middle of a 5-word burst. Expect all outputs at reset values the next cycle. A fresh header is then accepted normally.
- START issued while `task_complete` is already 1. Expect `done` two cycles after the header is accepted, then WAIT_LOW until `task_complete` falls.
